// File: rtl/dot_product_requant_pack.sv
// Requantizes signed dot-product sums to int8 (bias, rounding shift, saturate)
// and packs four lanes per 32-bit word into a small output FIFO.
module dot_product_requant_pack #(
   parameter int S          = 48,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic [S-1:0]  i_sum,
   input  logic          i_valid,
   input  logic          i_last,
   input  logic [S-1:0]  i_bias,
   input  logic [5:0]    i_shift,
   output logic [31:0]   o_data,
   output logic [3:0]    o_keep,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_err_sat,
   output logic          o_err_ovf
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic signed [S+1:0] MAX8 = (S+2)'(127);
   localparam logic signed [S+1:0] MIN8 = -((S+2)'(128));

   logic              v1, v2, v3;
   logic              l1, l2, l3;
   logic signed [S:0]   t1;
   logic signed [S+1:0] t2, t2_d, rnd;
   logic [7:0]        b3;
   logic              sat3;

   logic [1:0]        lane;
   logic [31:0]       word_q, word_d;
   logic [3:0]        keep_q, keep_d;
   logic              push;

   logic [35:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              full, pop, wr_en;

   // Half-LSB rounding term; absent when no shift is applied.
   always_comb begin
      rnd = '0;
      if (i_shift != 6'd0) rnd[i_shift - 6'd1] = 1'b1;
      t2_d = ($signed({t1[S], t1}) + rnd) >>> i_shift;
   end

   always_comb begin
      word_d = word_q;
      word_d[{lane, 3'b000} +: 8] = b3;
      keep_d = keep_q | (4'b0001 << lane);
      push   = v3 && ((lane == 2'd3) || l3);
   end

   assign o_valid = (count != '0);
   assign pop     = o_valid && i_ready;
   assign full    = (count == CW'(FIFO_DEPTH));
   assign wr_en   = push && (!full || pop);
   assign o_data  = o_valid ? mem[rd_ptr][31:0]  : 32'd0;
   assign o_keep  = o_valid ? mem[rd_ptr][35:32] : 4'd0;

   // Data path registers carry no reset; validity is tracked separately.
   always_ff @(posedge i_clk) begin
      t1 <= $signed({i_sum[S-1], i_sum}) + $signed({i_bias[S-1], i_bias});
      l1 <= i_last;
      t2 <= t2_d;
      l2 <= l1;
      l3 <= l2;
      if (t2 > MAX8) begin
         b3   <= 8'h7f;
         sat3 <= 1'b1;
      end else if (t2 < MIN8) begin
         b3   <= 8'h80;
         sat3 <= 1'b1;
      end else begin
         b3   <= t2[7:0];
         sat3 <= 1'b0;
      end
      if (wr_en) mem[wr_ptr] <= {keep_d, word_d};
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         lane      <= 2'd0;
         word_q    <= 32'd0;
         keep_q    <= 4'd0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         o_err_sat <= 1'b0;
         o_err_ovf <= 1'b0;
      end else begin
         v1 <= i_valid;
         v2 <= v1;
         v3 <= v2;
         if (v3) begin
            if (push) begin
               lane   <= 2'd0;
               word_q <= 32'd0;
               keep_q <= 4'd0;
            end else begin
               lane   <= lane + 2'd1;
               word_q <= word_d;
               keep_q <= keep_d;
            end
         end
         if (v3 && sat3) o_err_sat <= 1'b1;
         if (push && full && !pop) o_err_ovf <= 1'b1;
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
